// File: rtl/alu_issue_unit.sv
// Sequential issue front end for the combinational RV32 ALU: accepts R-type
// instructions, reads operands from a local regfile, drives the ALU, writes back.
module alu_issue_unit #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [XLEN-1:0]  alu_rs1,
  output logic [XLEN-1:0]  alu_rs2,
  output logic [31:0]      alu_instr,
  input  logic [XLEN-1:0]  alu_o,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt,
  input  logic             dbg_we,
  input  logic [4:0]       dbg_waddr,
  input  logic [XLEN-1:0]  dbg_wdata,
  input  logic [4:0]       dbg_raddr,
  output logic [XLEN-1:0]  dbg_rdata
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [6:0] OP_R = 7'b0110011;

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [NREG];

  // x0 is hardwired: never written, and masked on every read path anyway.
  function automatic logic [XLEN-1:0] rf_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? '0 : regs[idx];
  endfunction

  assign dbg_rdata = rf_rd(dbg_raddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      ir          <= '0;
      alu_rs1     <= '0;
      alu_rs2     <= '0;
      alu_instr   <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
      retire_cnt  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: begin
          // Debug writes share the IDLE slot with a handshake; READ next cycle sees them.
          if (dbg_we && dbg_waddr != 5'd0) regs[dbg_waddr] <= dbg_wdata;
          if (instr_valid) begin
            ir          <= instr;
            instr_ready <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
          if (ir[6:0] != OP_R) begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            alu_rs1   <= rf_rd(ir[19:15]);
            alu_rs2   <= rf_rd(ir[24:20]);
            alu_instr <= ir;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // wb_data doubles as the result register and holds outside WB.
          wb_valid <= 1'b1;
          wb_rd    <= ir[11:7];
          wb_data  <= alu_o;
          state    <= WB;
        end
        WB: begin
          if (wb_rd != 5'd0) regs[wb_rd] <= wb_data;
          retire_cnt  <= retire_cnt + CNT_W'(1);
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed + randomized bench for alu_issue_unit with a behavioural ALU and regfile model.
module tb_alu_issue_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          instr_ready;
  logic [31:0]   alu_rs1, alu_rs2, alu_instr, alu_o;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          illegal;
  logic [CW-1:0] retire_cnt;
  logic          dbg_we;
  logic [4:0]    dbg_waddr, dbg_raddr;
  logic [31:0]   dbg_wdata, dbg_rdata;

  int          passes = 0;
  int          checks = 0;
  logic [31:0] m [32];
  int          mcnt;

  alu_issue_unit #(.XLEN(32), .NREG(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_instr(alu_instr), .alu_o(alu_o), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal(illegal), .retire_cnt(retire_cnt),
    .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    case (ins[14:12])
      3'd0: return ins[30] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_o = alu_f(alu_instr, alu_rs1, alu_rs2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic rd_dbg(input logic [4:0] a, output logic [31:0] d);
    dbg_raddr = a;
    #1;
    d = dbg_rdata;
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
    tick();
    dbg_we = 1'b0;
    if (a != 5'd0) m[a] = d;
  endtask

  // One instruction end to end; checks latency, handshake, pulses and writeback.
  task automatic run_instr(input logic [31:0] ins, input bit hold, input bit noise);
    logic [31:0] exp, rv;
    logic [4:0]  rd;
    bit          legal;
    int          n;
    legal = (ins[6:0] == 7'b0110011);
    rd    = ins[11:7];
    instr = ins; instr_valid = 1'b1; n = 0;
    while (!instr_ready && n < 16) begin tick(); n++; end
    chk("accept_ready", {31'b0, instr_ready}, 32'd1);
    exp = alu_f(ins, m[ins[19:15]], m[ins[24:20]]);
    tick();                                   // T+1
    instr_valid = hold && legal;
    dbg_we = noise; dbg_waddr = ins[19:15]; dbg_wdata = $urandom;
    chk("ready_t1", {31'b0, instr_ready}, 32'd0);
    chk("wbv_t1", {31'b0, wb_valid}, 32'd0);
    tick();                                   // T+2
    if (!legal) begin
      dbg_we = 1'b0;
      chk("illegal_pulse", {31'b0, illegal}, 32'd1);
      chk("ready_after_illegal", {31'b0, instr_ready}, 32'd1);
      chk("wbv_illegal", {31'b0, wb_valid}, 32'd0);
      tick();
      chk("illegal_clear", {31'b0, illegal}, 32'd0);
      chk("cnt_illegal", {28'b0, retire_cnt}, mcnt);
      rd_dbg(ins[19:15], rv);
      chk("rf_illegal", rv, m[ins[19:15]]);
      return;
    end
    chk("ready_t2", {31'b0, instr_ready}, 32'd0);
    chk("wbv_t2", {31'b0, wb_valid}, 32'd0);
    tick();                                   // T+3
    chk("wbv_t3", {31'b0, wb_valid}, 32'd1);
    chk("ready_t3", {31'b0, instr_ready}, 32'd0);
    chk("wb_rd", {27'b0, wb_rd}, {27'b0, rd});
    chk("wb_data", wb_data, exp);
    tick();                                   // back in IDLE
    dbg_we = 1'b0;
    if (rd != 5'd0) m[rd] = exp;
    mcnt = (mcnt + 1) % (1 << CW);
    chk("wbv_done", {31'b0, wb_valid}, 32'd0);
    chk("ready_done", {31'b0, instr_ready}, 32'd1);
    chk("retire_cnt", {28'b0, retire_cnt}, mcnt);
    chk("wb_data_hold", wb_data, exp);
    rd_dbg(rd, rv);
    chk("rf_rd", rv, m[rd]);
    rd_dbg(ins[19:15], rv);
    chk("rf_rs1", rv, m[ins[19:15]]);
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_illegal);
    logic [2:0]  f3;
    logic [6:0]  op, f7;
    f3 = 3'($urandom_range(0, 7));
    f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    op = 7'b0110011;
    if (allow_illegal && $urandom_range(0, 7) == 0)
      case ($urandom_range(0, 3))
        0: op = 7'h13;
        1: op = 7'h03;
        2: op = 7'h63;
        default: op = 7'h37;
      endcase
    return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), op};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    mcnt = 0;
  endtask

  initial begin
    logic [31:0] rv;
    rst = 1'b0; instr_valid = 1'b0; instr = '0;
    dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0; dbg_raddr = '0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    mcnt = 0;

    // Reset state
    apply_reset();
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_wbv", {31'b0, wb_valid}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_cnt", {28'b0, retire_cnt}, 32'd0);
    chk("rst_alu_rs1", alu_rs1, 32'd0);
    chk("rst_alu_instr", alu_instr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);

    // ADD, then back-to-back SUB/OR/AND, then ADD to x0
    dbg_write(5'd1, 32'h0000000A);
    dbg_write(5'd2, 32'h00000003);
    run_instr(32'h002081B3, 1'b0, 1'b0);
    chk("add_x3", m[3], 32'h0000000D);
    run_instr(32'h402081B3, 1'b1, 1'b0);
    run_instr(32'h0020E233, 1'b1, 1'b0);
    run_instr(32'h0020F2B3, 1'b0, 1'b0);
    rd_dbg(5'd3, rv); chk("sub_x3", rv, 32'h00000007);
    rd_dbg(5'd4, rv); chk("or_x4", rv, 32'h0000000B);
    rd_dbg(5'd5, rv); chk("and_x5", rv, 32'h00000002);
    run_instr(32'h00208033, 1'b0, 1'b0);
    rd_dbg(5'd0, rv); chk("x0_zero", rv, 32'd0);

    // Illegal opcode, debug write to x0, debug noise outside IDLE
    run_instr(32'h00000013, 1'b0, 1'b0);
    dbg_write(5'd0, 32'hFFFFFFFF);
    rd_dbg(5'd0, rv); chk("dbg_x0", rv, 32'd0);
    run_instr(32'h002081B3, 1'b0, 1'b1);

    // Debug write in the same cycle as the handshake is seen by READ
    dbg_we = 1'b1; dbg_waddr = 5'd1; dbg_wdata = 32'h00000100;
    m[1] = 32'h00000100;
    run_instr(32'h002083B3, 1'b0, 1'b0);
    rd_dbg(5'd7, rv); chk("dbg_fwd_x7", rv, 32'h00000103);

    // Reset during EXEC abandons the instruction
    instr = 32'h002081B3; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    dbg_we = 1'b1; dbg_waddr = 5'd9; dbg_wdata = 32'hDEADBEEF;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; dbg_we = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    mcnt = 0;
    chk("rstx_wbv", {31'b0, wb_valid}, 32'd0);
    chk("rstx_ready", {31'b0, instr_ready}, 32'd1);
    chk("rstx_cnt", {28'b0, retire_cnt}, 32'd0);
    chk("rstx_wb_data", wb_data, 32'd0);
    tick();
    chk("rstx_no_wb", {31'b0, wb_valid}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = 5'(i);
      tick();
      chk("rstx_rf", dbg_rdata, 32'd0);
    end

    // Counter wrap with random legal traffic
    for (int i = 1; i < 32; i++) dbg_write(5'(i), $urandom);
    for (int i = 0; i < 15; i++) run_instr(rand_instr(1'b0), 1'b0, $urandom_range(0, 1) == 1);
    chk("cnt_15", {28'b0, retire_cnt}, 32'd15);
    run_instr(rand_instr(1'b0), 1'b0, 1'b0);
    chk("cnt_wrap", {28'b0, retire_cnt}, 32'd0);

    // Random mix including illegal opcodes and debug preloads
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) dbg_write(5'($urandom), $urandom);
      run_instr(rand_instr(1'b1), 1'b0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
Sequential front end that feeds the team's combinational RV32 ALU (operand inputs rs1/rs2, instruction word, result output). It accepts R-type instructions over a valid/ready handshake, reads operands from an internal register file, drives the ALU, samples its result and writes it back to rd. A debug port allows the register file to be preloaded and inspected.

Parameters:
XLEN, 32, datapath and register width
NREG, 32, number of architectural registers (index width 5)
CNT_W, 16, retire counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr  in  32  RV32 instruction word
instr_ready  out  1  unit can accept (high only in IDLE)
alu_rs1  out  XLEN  operand 1 to ALU (registered)
alu_rs2  out  XLEN  operand 2 to ALU (registered)
alu_instr  out  32  instruction word to ALU (registered)
alu_o  in  XLEN  ALU result (combinational from alu_* outputs)
wb_valid  out  1  one-cycle pulse, writeback occurring
wb_rd  out  5  destination register of writeback
wb_data  out  XLEN  value written
illegal  out  1  one-cycle pulse, non-R-type instruction dropped
retire_cnt  out  CNT_W  count of completed writebacks, wraps
dbg_we  in  1  debug register write
dbg_waddr  in  5  debug write index
dbg_wdata  in  XLEN  debug write data
dbg_raddr  in  5  debug read index
dbg_rdata  out  XLEN  combinational read of regfile[dbg_raddr]

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset: state IDLE; all regfile entries, alu_rs1, alu_rs2, alu_instr, wb_rd, wb_data = 0; wb_valid, illegal = 0; retire_cnt = 0; instr_ready = 1 in the cycle after reset. Reset mid-operation abandons the instruction: no writeback, no pulse.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE. instr_ready = (state == IDLE).
- IDLE: on instr_valid && instr_ready, latch instr into IR and go to READ. Otherwise stay.
- READ: if IR[6:0] != 7'b0110011, pulse illegal for one cycle (asserted while in the following cycle, in IDLE) and return to IDLE with no write. Otherwise load alu_rs1 = reg[IR[19:15]], alu_rs2 = reg[IR[24:20]], alu_instr = IR, and go to EXEC.
- EXEC: alu_* outputs are stable. At the end of the cycle, sample alu_o into the result register and go to WB.
- WB: wb_valid = 1, wb_rd = IR[11:7], wb_data = result. At the end of the cycle, write reg[rd] unless rd == 0, increment retire_cnt (mod 2^CNT_W), and go to IDLE. rd == 0 still pulses wb_valid and counts, but x0 stays 0.
- Latency: handshake at cycle T gives wb_valid in cycle T+3. Throughput is one instruction per 4 cycles. No hazards, because the write completes before the next READ.
- x0 reads always return 0, including via dbg_rdata.
- dbg_we is honoured only in IDLE; it is ignored in other states. dbg writes to index 0 are ignored. If dbg_we and an instruction handshake occur in the same IDLE cycle, both take effect; the READ in the next cycle sees the debug-written value.
- wb_rd and wb_data hold their last values outside WB.
- Operand arithmetic is entirely the ALU's. This unit performs no width extension; all values are XLEN bits.

Test Plan:
- Reset, then dbg writes x1=0x0000000A and x2=0x00000003; issue 0x002081B3 (ADD x3) at cycle T -> wb_valid at T+3, wb_rd=3, wb_data=0x0000000D, dbg read x3=0x0000000D, retire_cnt=1.
- Issue 0x402081B3 (SUB x3), then 0x0020E233 (OR x4), then 0x0020F2B3 (AND x5) back-to-back with instr_valid held high -> instr_ready low for 3 cycles between accepts; results x3=0x00000007, x4=0x0000000B, x5=0x00000002.
- Issue 0x00208033 (ADD, rd=0) -> wb_valid pulses with wb_data=0x0000000D, x0 still reads 0, retire_cnt increments.
- Issue 0x00000013 (opcode OP-IMM) -> illegal pulses once, no wb_valid, regfile and retire_cnt unchanged, instr_ready high again 2 cycles after accept.
- Assert rst during EXEC of an ADD -> no wb_valid; all registers read 0; instr_ready=1 after reset; dbg_we during EXEC has no effect.
- Preload retire_cnt near wrap via 2^16-1 completions (or a CNT_W=4 build with 15 completions), then one more -> retire_cnt=0.
